aesl_axis_stall_probe: RTL

Cosimulation-side AXI-Stream stall probe. It watches the TVALID/TREADY pairs on the top-level stream ports of the DUT and drives the per-stream `axis_block_sigs` vector consumed by the dataflow deadlock monitor. It also closes the loop on that monitor: it confirms the monitor's `block`/`axis_block_info` outputs and latches a sticky deadlock report for the testbench. It sits in the sim-only wrapper between the stream ports, the AESL transactors and the deadlock monitor.

---
 rtl/aesl_axis_stall_probe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/aesl_axis_stall_probe.sv
// aesl_axis_stall_probe
//
// Sim-side AXI-Stream stall probe. It watches the TVALID/TREADY pair of each
// top-level stream and flags the channels that have been stalled for
// STALL_THRESH consecutive cycles. Those flags feed the dataflow deadlock
// monitor. The probe then confirms the monitor's block output over CONFIRM
// consecutive cycles and latches a sticky report for the testbench.
//
// Ports
//   clock           : single clock, rising edge
//   reset           : synchronous, active-high
//   ch_tvalid       : TVALID per channel
//   ch_tready       : TREADY per channel
//   axis_block_sigs : per-channel "stalled past threshold", registered
//   mon_block       : block output of the deadlock monitor
//   mon_info        : axis_block_info output of the deadlock monitor
//   deadlock_flag   : sticky confirmed deadlock
//   deadlock_info   : mon_info captured in the confirming cycle
//   deadlock_cycle  : cycle counter captured in the confirming cycle
//
// Channel FSM (one per channel)
//   state      | meaning
//   ST_IDLE    | channel not blocked, cnt = 0
//   ST_WAIT    | blocked for fewer than STALL_THRESH cycles
//   ST_BLOCKED | blocked past threshold, flag asserted, cnt saturates at 255
//
// Report FSM
//   state       | meaning
//   RP_RUN      | monitor not blocking
//   RP_CONF     | monitor blocking, confirm count running
//   RP_LATCHED  | report captured, terminal until reset

module aesl_axis_stall_probe #(
  parameter int unsigned       NUM_CH       = 2,
  parameter logic [NUM_CH-1:0] DIR_MASK     = NUM_CH'(2'b10),
  parameter int unsigned       STALL_THRESH = 16,
  parameter int unsigned       CONFIRM      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_tvalid,
  input  logic [NUM_CH-1:0]     ch_tready,
  output logic [NUM_CH-1:0]     axis_block_sigs,
  input  logic                  mon_block,
  input  logic [2*NUM_CH-1:0]   mon_info,
  output logic                  deadlock_flag,
  output logic [2*NUM_CH-1:0]   deadlock_info,
  output logic [31:0]           deadlock_cycle
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_BLOCKED = 2'd2;

  localparam logic [1:0] RP_RUN     = 2'd0;
  localparam logic [1:0] RP_CONF    = 2'd1;
  localparam logic [1:0] RP_LATCHED = 2'd2;

  localparam logic [7:0] THRESH = 8'(STALL_THRESH);
  localparam logic [7:0] CONF_N = 8'(CONFIRM);

  logic [31:0] cyc;

  always_ff @(posedge clock) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic       cond;
      logic [1:0] st, st_n;
      logic [7:0] cnt, cnt_n, cnt_inc;
      logic       blk_q;

      // Input streams stall on an empty source, output streams on backpressure.
      assign cond = DIR_MASK[i] ? (ch_tvalid[i] & ~ch_tready[i])
                                : (ch_tready[i] & ~ch_tvalid[i]);

      assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

      always_comb begin
        st_n  = st;
        cnt_n = cnt;
        if (!cond) begin
          st_n  = ST_IDLE;
          cnt_n = '0;
        end else begin
          case (st)
            ST_IDLE: begin
              cnt_n = 8'd1;
              st_n  = (THRESH <= 8'd1) ? ST_BLOCKED : ST_WAIT;
            end
            ST_WAIT: begin
              cnt_n = cnt_inc;
              if (cnt_inc >= THRESH) st_n = ST_BLOCKED;
            end
            ST_BLOCKED: cnt_n = cnt_inc;
            default: begin
              st_n  = ST_IDLE;
              cnt_n = '0;
            end
          endcase
        end
      end

      // Flag registered from the next state so it rises in the same cycle
      // the FSM enters ST_BLOCKED.
      always_ff @(posedge clock) begin
        if (reset) begin
          st    <= ST_IDLE;
          cnt   <= '0;
          blk_q <= 1'b0;
        end else begin
          st    <= st_n;
          cnt   <= cnt_n;
          blk_q <= (st_n == ST_BLOCKED);
        end
      end

      assign axis_block_sigs[i] = blk_q;
    end
  endgenerate

  logic [1:0] rp, rp_n;
  logic [7:0] conf_cnt, conf_cnt_n;
  logic [7:0] conf_inc;

  assign conf_inc = conf_cnt + 8'd1;

  always_comb begin
    rp_n       = rp;
    conf_cnt_n = conf_cnt;
    case (rp)
      RP_RUN: begin
        if (mon_block) begin
          conf_cnt_n = 8'd1;
          rp_n       = (CONF_N <= 8'd1) ? RP_LATCHED : RP_CONF;
        end
      end
      RP_CONF: begin
        if (!mon_block) begin
          conf_cnt_n = '0;
          rp_n       = RP_RUN;
        end else begin
          conf_cnt_n = conf_inc;
          if (conf_inc >= CONF_N) rp_n = RP_LATCHED;
        end
      end
      RP_LATCHED: rp_n = RP_LATCHED;
      default: begin
        rp_n       = RP_RUN;
        conf_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rp             <= RP_RUN;
      conf_cnt       <= '0;
      deadlock_flag  <= 1'b0;
      deadlock_info  <= '0;
      deadlock_cycle <= '0;
    end else begin
      rp       <= rp_n;
      conf_cnt <= conf_cnt_n;
      // Capture only on the entering edge; LATCHED ignores later inputs.
      if (rp != RP_LATCHED && rp_n == RP_LATCHED) begin
        deadlock_flag  <= 1'b1;
        deadlock_info  <= mon_info;
        deadlock_cycle <= cyc;
      end
    end
  end

endmodule
